// File: rtl/gf256_inverse_seq_if.sv
// Handshake bundle for the sequential GF(2^8) inverter.
// The master drives operands and consumes results. The slave is the inverter.
interface gf256_inverse_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/gf256_inverse_seq.sv
// Sequential GF(2^8) multiplicative inverter: out = a^254 (0 maps to 0).
// The result is built by eight square-and-multiply iterations, one per clock.
// Define GF256_INV_SBOX_EN to apply the AES affine transform to the inverse
// when the result is loaded, which turns the block into the forward S-box.
// The affine transform is only meaningful with POLY = 8'h1B.
module gf256_inverse_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input logic                clk,
  input logic                rst,
  gf256_inverse_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] r_q, r_d;
  logic [2:0] step_q, step_d;
  logic [7:0] out_data_q, out_data_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  logic [7:0] sq_s;
  logic [7:0] sqmul_s;
  logic [7:0] result_s;

  // Multiply by x, reduced modulo x^8 + POLY.
  function automatic logic [7:0] xtime(input logic [7:0] t);
    return {t[6:0], 1'b0} ^ (POLY & {8{t[7]}});
  endfunction

  // Bit-serial shift-and-add multiply, unrolled into combinational logic.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (t & {8{y[i]}});
      t = xtime(t);
    end
    return p;
  endfunction

`ifdef GF256_INV_SBOX_EN
  // AES forward affine transform applied to the field inverse.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
`endif

  // One square-and-multiply iteration on the accumulator.
  always_comb begin
    sq_s    = gf_mul(r_q, r_q);
    sqmul_s = gf_mul(sq_s, a_q);
`ifdef GF256_INV_SBOX_EN
    result_s = affine(sq_s);
`else
    result_s = sq_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. The final step is the one with the counter at 7.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (step_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values. Handshake flags follow the next state so that they are registered.
  always_comb begin
    a_d         = a_q;
    r_d         = r_q;
    step_d      = step_q;
    out_data_d  = out_data_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.in_data;
          r_d    = 8'h01;
          step_d = 3'd0;
        end else begin
          a_d    = a_q;
        end
      end
      ST_BUSY: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          r_d        = sq_s;
          out_data_d = result_s;
        end else begin
          r_d        = sqmul_s;
        end
      end
      ST_DONE: begin
        step_d = step_q;
      end
      default: begin
        step_d = 3'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= 8'h00;
      r_q         <= 8'h01;
      step_q      <= 3'd0;
      out_data_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      r_q         <= r_d;
      step_q      <= step_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
